// File: rtl/ascon_inv_permutation.sv
// Iterative inverse of the Ascon permutation for 6, 8 or 12 rounds, with a start/done handshake.
// Build option ASCON_INV_UNROLL2_EN retires two inverse rounds per cycle.
module ascon_inv_permutation (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [4:0]   rounds,
   input  logic [319:0] state_in,
   output logic         busy,
   output logic         done,
   output logic [319:0] state_out
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

`ifdef ASCON_INV_UNROLL2_EN
   localparam logic [3:0] STEP = 4'd2;
`else
   localparam logic [3:0] STEP = 4'd1;
`endif

   function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
      int unsigned m;
      m = n % 64;
      if (m == 0) return x;
      return (x >> m) | (x << (64 - m));
   endfunction

   function automatic logic [63:0] rol64(input logic [63:0] x, input int unsigned n);
      int unsigned m;
      m = n % 64;
      if (m == 0) return x;
      return (x << m) | (x >> (64 - m));
   endfunction

   // Coefficients of (1 + z^a + z^b)^-1 modulo z^64 + 1 (z^k = rotate right by k). Since the
   // element raised to 64 is 1, its inverse is the product of its first six squarings.
   function automatic logic [63:0] inv_mask(input int unsigned a, input int unsigned b);
      logic [63:0] p;
      p = 64'd1;
      for (int k = 0; k < 6; k++) begin
         p = p ^ rol64(p, (a << k) % 64) ^ rol64(p, (b << k) % 64);
      end
      return p;
   endfunction

   localparam logic [63:0] MASK0 = inv_mask(19, 28);
   localparam logic [63:0] MASK1 = inv_mask(61, 39);
   localparam logic [63:0] MASK2 = inv_mask(1, 6);
   localparam logic [63:0] MASK3 = inv_mask(10, 17);
   localparam logic [63:0] MASK4 = inv_mask(7, 41);

   function automatic logic [63:0] inv_lin(input logic [63:0] x, input logic [63:0] mask);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) begin
         if (mask[i]) y = y ^ ror64(x, i);
      end
      return y;
   endfunction

   function automatic logic [4:0] fwd_sbox(input logic [4:0] v);
      logic [4:0] r;
      unique case (v)
         5'h00: r = 5'h04;  5'h01: r = 5'h0b;  5'h02: r = 5'h1f;  5'h03: r = 5'h14;
         5'h04: r = 5'h1a;  5'h05: r = 5'h15;  5'h06: r = 5'h09;  5'h07: r = 5'h02;
         5'h08: r = 5'h1b;  5'h09: r = 5'h05;  5'h0a: r = 5'h08;  5'h0b: r = 5'h12;
         5'h0c: r = 5'h1d;  5'h0d: r = 5'h03;  5'h0e: r = 5'h06;  5'h0f: r = 5'h1c;
         5'h10: r = 5'h1e;  5'h11: r = 5'h13;  5'h12: r = 5'h07;  5'h13: r = 5'h0e;
         5'h14: r = 5'h00;  5'h15: r = 5'h0d;  5'h16: r = 5'h11;  5'h17: r = 5'h18;
         5'h18: r = 5'h10;  5'h19: r = 5'h0c;  5'h1a: r = 5'h01;  5'h1b: r = 5'h19;
         5'h1c: r = 5'h16;  5'h1d: r = 5'h0a;  5'h1e: r = 5'h0f;  default: r = 5'h17;
      endcase
      return r;
   endfunction

   // Inverse table is derived from the forward one and folds to constants.
   function automatic logic [4:0] inv_sbox(input logic [4:0] v);
      logic [4:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (fwd_sbox(5'(i)) == v) r = 5'(i);
      end
      return r;
   endfunction

   function automatic logic [319:0] inv_round(input logic [319:0] s, input logic [7:0] c);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [4:0]  col;
      x0 = inv_lin(s[319:256], MASK0);
      x1 = inv_lin(s[255:192], MASK1);
      x2 = inv_lin(s[191:128], MASK2);
      x3 = inv_lin(s[127:64],  MASK3);
      x4 = inv_lin(s[63:0],    MASK4);
      for (int j = 0; j < 64; j++) begin
         col   = inv_sbox({x0[j], x1[j], x2[j], x3[j], x4[j]});
         x0[j] = col[4];
         x1[j] = col[3];
         x2[j] = col[2];
         x3[j] = col[1];
         x4[j] = col[0];
      end
      x2 = x2 ^ {56'd0, c};
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic logic [7:0] rc(input logic [7:0] base, input logic [3:0] ctr);
      logic [7:0] k;
      k = {4'd0, ctr} - 8'd1;
      return base - ((k << 4) - k);
   endfunction

   logic         fsm_q;
   logic [3:0]   ctr_q;
   logic [7:0]   base_q;
   logic [319:0] work_q;
   logic [319:0] out_q;
   logic         done_q;

   logic [3:0]   eff_rounds;
   logic [7:0]   eff_base;
   logic [319:0] round_nxt;

   always_comb begin
      eff_rounds = 4'd12;
      eff_base   = 8'hf0;
      case (rounds)
         5'd6: begin
            eff_rounds = 4'd6;
            eff_base   = 8'h96;
         end
         5'd8: begin
            eff_rounds = 4'd8;
            eff_base   = 8'hb4;
         end
         default: begin
            eff_rounds = 4'd12;
            eff_base   = 8'hf0;
         end
      endcase
   end

`ifdef ASCON_INV_UNROLL2_EN
   logic [319:0] round_mid;

   always_comb begin
      round_mid = inv_round(work_q, rc(base_q, ctr_q));
      round_nxt = inv_round(round_mid, rc(base_q, ctr_q - 4'd1));
   end
`else
   always_comb begin
      round_nxt = inv_round(work_q, rc(base_q, ctr_q));
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q  <= ST_IDLE;
         ctr_q  <= '0;
         base_q <= '0;
         work_q <= '0;
         out_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (fsm_q)
            ST_IDLE: begin
               if (start) begin
                  work_q <= state_in;
                  ctr_q  <= eff_rounds;
                  base_q <= eff_base;
                  fsm_q  <= ST_RUN;
               end
            end
            default: begin
               work_q <= round_nxt;
               ctr_q  <= ctr_q - STEP;
               if (ctr_q == STEP) begin
                  out_q  <= round_nxt;
                  done_q <= 1'b1;
                  fsm_q  <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign busy      = (fsm_q == ST_RUN);
   assign done      = done_q;
   assign state_out = out_q;

endmodule

// File: tb/tb_ascon_inv_permutation.sv
// Bench for ascon_inv_permutation: builds inputs with a forward Ascon model and expects the
// original state back (roundtrip), plus latency, handshake, start-while-busy and reset cases.
module tb_ascon_inv_permutation;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [4:0]   rounds;
   logic [319:0] state_in;
   logic         busy;
   logic         done;
   logic [319:0] state_out;

   int n_checks = 0;
   int n_fail   = 0;

   ascon_inv_permutation dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rounds    (rounds),
      .state_in  (state_in),
      .busy      (busy),
      .done      (done),
      .state_out (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Forward Ascon permutation: constant addition, S-box layer, linear layer.
   function automatic logic [319:0] fwd_perm(input logic [319:0] s, input int r);
      logic [63:0] x [5];
      logic [4:0]  v;
      logic [7:0]  c;
      for (int i = 0; i < 5; i++) x[i] = s[319 - 64 * i -: 64];
      for (int i = 0; i < r; i++) begin
         c = 8'(240 - (12 - r + i) * 15);
         x[2] = x[2] ^ {56'd0, c};
         for (int j = 0; j < 64; j++) begin
            v = SBOX[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}];
            x[0][j] = v[4];
            x[1][j] = v[3];
            x[2][j] = v[2];
            x[3][j] = v[1];
            x[4][j] = v[0];
         end
         x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
         x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
         x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
         x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
         x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   function automatic int eff(input logic [4:0] r);
      if (r == 5'd6) return 6;
      if (r == 5'd8) return 8;
      return 12;
   endfunction

   function automatic int exp_lat(input int e);
`ifdef ASCON_INV_UNROLL2_EN
      return e / 2;
`else
      return e;
`endif
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[i * 32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Counts cycles from the current point until done is seen, bounded.
   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic do_op(input string name, input logic [319:0] s0, input logic [4:0] r);
      int lat;
      @(negedge clk);
      start    = 1'b1;
      state_in = fwd_perm(s0, eff(r));
      rounds   = r;
      @(posedge clk);
      #1;
      start    = 1'b0;
      state_in = rand320();
      rounds   = 5'($urandom);
      chk_int({name, " busy"}, int'(busy), 1);
      wait_done(lat);
      chk_int({name, " latency"}, lat, exp_lat(eff(r)));
      chk({name, " state_out"}, state_out, s0);
      @(posedge clk);
      #1;
      chk_int({name, " done pulse"}, int'(done), 0);
   endtask

   typedef struct {
      string        name;
      logic [319:0] s0;
      logic [4:0]   r;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [8];
      logic [4:0]  rsel [8];
      logic [319:0] a0, b0;
      int          lat;

      vecs[0] = '{"zero r12",   '0,        5'd12};
      vecs[1] = '{"rand r6",    rand320(), 5'd6};
      vecs[2] = '{"rand r8",    rand320(), 5'd8};
      vecs[3] = '{"rand r12",   rand320(), 5'd12};
      vecs[4] = '{"inv r5",     rand320(), 5'd5};
      vecs[5] = '{"inv r0",     rand320(), 5'd0};
      vecs[6] = '{"inv r31",    rand320(), 5'd31};
      vecs[7] = '{"ones r6",    '1,        5'd6};
      rsel = '{5'd6, 5'd8, 5'd12, 5'd7, 5'd13, 5'd6, 5'd8, 5'd12};

      // Reset held with start asserted.
      rst_n    = 1'b0;
      start    = 1'b1;
      rounds   = 5'd12;
      state_in = rand320();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk_int("reset busy", int'(busy), 0);
         chk_int("reset done", int'(done), 0);
         chk("reset state_out", state_out, '0);
      end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) do_op(vecs[i].name, vecs[i].s0, vecs[i].r);
      for (int i = 0; i < 4; i++) do_op("random", rand320(), rsel[$urandom_range(7, 0)]);

      // Start pulsed while busy is ignored; back-to-back start on the done cycle is taken.
      a0 = rand320();
      b0 = rand320();
      @(negedge clk);
      start    = 1'b1;
      state_in = fwd_perm(a0, 12);
      rounds   = 5'd12;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      while (done !== 1'b1 && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 3) begin
            start    = 1'b1;
            state_in = rand320();
            rounds   = 5'd6;
         end
         if (lat == 4) start = 1'b0;
      end
      chk_int("busy-start latency", lat, exp_lat(12));
      chk("busy-start state_out", state_out, a0);
      start    = 1'b1;
      state_in = fwd_perm(b0, 8);
      rounds   = 5'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk_int("busy-start single done", int'(done), 0);
      chk_int("b2b accepted", int'(busy), 1);
      wait_done(lat);
      chk_int("b2b latency", lat, exp_lat(8));
      chk("b2b state_out", state_out, b0);

      // Mid-run reset aborts immediately.
      @(negedge clk);
      start    = 1'b1;
      state_in = fwd_perm(rand320(), 12);
      rounds   = 5'd12;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_int("midrst busy", int'(busy), 0);
      chk_int("midrst done", int'(done), 0);
      chk("midrst state_out", state_out, '0);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk_int("midrst no done", int'(done), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op("after reset", rand320(), 5'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
